sys_arr_gemm_sequencer: RTL and testbench
=========================================

Name: sys_arr_gemm_sequencer

Overview:
- Sequences one GEMM tile through the systolic array: loads N weight rows, waits for array FIFO space, then streams N input rows with their matching partial-sum rows.
- Collects N output rows and writes them back to the scratchpad.
- Sits between the tile command queue and the array's memory-side port (drives weight_en/input_en/partial_en/row_in_en/row_ps_en/array_in/array_in_partials; consumes drained/fifo_has_space/out_en/row_out/array_output).
- One command in flight at a time.

Parameters:
- N, 4, array dimension (rows = columns)
- DW, 16, element width in bits
- AW, 10, scratchpad row-address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  tile command valid
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_w_base, cmd_x_base, cmd_ps_base, cmd_out_base  in  AW each  base row addresses for weights, inputs, partials, outputs
- rda_en  out  1  operand read strobe
- rda_addr  out  AW  operand read address
- rda_data  in  DW*N  operand row, valid exactly 1 cycle after rda_en
- rdp_en  out  1  partial read strobe
- rdp_addr  out  AW  partial read address
- rdp_data  in  DW*N  partial row, valid 1 cycle after rdp_en
- weight_en, input_en, partial_en  out  1 each  array strobes
- row_in_en  out  clog2(N)  operand row index
- row_ps_en  out  clog2(N)  partial row index
- array_in, array_in_partials  out  DW*N  array row data
- fifo_has_space, drained, out_en  in  1 each  array status
- row_out  in  clog2(N)  output row index
- array_output  in  DW*N  output row data
- wr_en  out  1  writeback strobe
- wr_addr  out  AW  writeback address
- wr_data  out  DW*N  writeback data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at tile completion
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, any time including mid-tile):
  - state to IDLE; counters to 0.
  - All outputs 0 except cmd_ready, which is 1.
  - In-flight read data is discarded; no strobe follows reset.
- States: IDLE, LOAD_W, WAIT_SPACE, STREAM_X, DRAIN, DONE.
- IDLE:
  - cmd_ready=1; on cmd_valid&cmd_ready latch all four bases, clear counters, go LOAD_W.
- LOAD_W:
  - Cycle k=0..N-1: rda_en=1, rda_addr=w_base+k.
  - After k=N-1 go WAIT_SPACE.
- Read-return stage (shared): one cycle after an issue, drive the strobe with data=rda_data/rdp_data and row index=k (registered).
  - Weight rows use weight_en; input rows use input_en plus partial_en.
  - Strobes are single-cycle per row and never overlap weight vs input.
- WAIT_SPACE:
  - Stay while fifo_has_space=0.
  - When 1, go STREAM_X. fifo_has_space is sampled only here; a later deassert does not stall the tile.
- STREAM_X:
  - Cycle k=0..N-1: rda_en=rdp_en=1, rda_addr=x_base+k, rdp_addr=ps_base+k.
  - Row k gives input_en=partial_en=1, row_in_en=row_ps_en=k.
  - After k=N-1 go DRAIN.
- Writeback (STREAM_X and DRAIN):
  - Each cycle with out_en=1: next cycle wr_en=1, wr_addr=out_base+row_out, wr_data=array_output; increment out_cnt.
- DRAIN:
  - Leave when out_cnt==N and drained==1 (same or later cycle), go DONE.
- DONE:
  - done=1 for one cycle, go IDLE. cmd_ready returns 1 the cycle after done.
- Address arithmetic: base+k is modulo 2^AW; wrap is silent.
- err (sticky, cleared only by rst):
  - set on out_en in IDLE/LOAD_W/WAIT_SPACE/DONE (no writeback issued);
  - set on out_en when out_cnt==N already (write suppressed).
- Latency (no FIFO stall):
  - cmd accepted at cycle 0; weight_en cycles 2..N+1.
  - input_en cycles N+3..2N+2.
  - done 1 cycle after the later of the Nth wr_en and drained.

Test Plan:
- N=4, bases w=0x010,x=0x020,ps=0x030,out=0x040, fifo_has_space=1, model emits out_en rows 0..3 at cycles 20..23 with drained at 24:
  - weight_en cycles 2-5 rows 0-3 from addr 0x010-0x013;
  - input_en/partial_en cycles 7-10;
  - wr_en cycles 21-24 to 0x040-0x043;
  - done at 25.
- fifo_has_space=0 for 10 cycles after weight load: no rda_en/rdp_en in WAIT_SPACE; input_en starts 2 cycles after space rises; no stall when space drops during STREAM_X.
- cmd_x_base=0x3FE, AW=10: input reads hit 0x3FE,0x3FF,0x000,0x001.
- Out-of-order row_out 3,1,0,2: wr_addr follows row_out (0x043,0x041,0x040,0x042); done only after all 4 and drained.
- Stray out_en in IDLE: no wr_en, err=1 and stays 1 through the next good tile; a 5th out_en in DRAIN is suppressed.
- rst asserted mid-STREAM_X (row 2): all strobes 0 immediately, cmd_ready=1; a fresh command then completes normally.

Source files
------------

// File: rtl/sys_arr_gemm_sequencer.sv
// GEMM tile sequencer for the systolic array: loads N weight rows, waits for
// array FIFO space, streams N input/partial rows, then writes N result rows back.
module sys_arr_gemm_sequencer #(
  parameter  int N  = 4,
  parameter  int DW = 16,
  parameter  int AW = 10,
  localparam int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_w_base,
  input  logic [AW-1:0]   cmd_x_base,
  input  logic [AW-1:0]   cmd_ps_base,
  input  logic [AW-1:0]   cmd_out_base,
  output logic            rda_en,
  output logic [AW-1:0]   rda_addr,
  input  logic [DW*N-1:0] rda_data,
  output logic            rdp_en,
  output logic [AW-1:0]   rdp_addr,
  input  logic [DW*N-1:0] rdp_data,
  output logic            weight_en,
  output logic            input_en,
  output logic            partial_en,
  output logic [CW-1:0]   row_in_en,
  output logic [CW-1:0]   row_ps_en,
  output logic [DW*N-1:0] array_in,
  output logic [DW*N-1:0] array_in_partials,
  input  logic            fifo_has_space,
  input  logic            drained,
  input  logic            out_en,
  input  logic [CW-1:0]   row_out,
  input  logic [DW*N-1:0] array_output,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW*N-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_W     = 3'd1,
    WAIT_SPACE = 3'd2,
    STREAM_X   = 3'd3,
    DRAIN      = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic [CW-1:0] K_LAST   = CW'(N - 1);
  localparam logic [CW:0]   CNT_FULL = (CW+1)'(N);

  state_t          state_r, state_s;
  logic [CW-1:0]   k_r, k_s;
  logic            accept_s;
  logic [AW-1:0]   w_base_r, x_base_r, ps_base_r, out_base_r;
  logic [AW-1:0]   w_base_s, x_base_s, ps_base_s;
  logic [CW:0]     out_cnt_r;
  logic            wb_ok_s, stray_s;
  logic [AW-1:0]   rda_addr_s, rdp_addr_s;
  logic            rda_en_r, rdp_en_r;
  logic [AW-1:0]   rda_addr_r, rdp_addr_r;
  logic            ld_w_r, ld_x_r;
  logic [CW-1:0]   ld_idx_r;
  logic            wr_en_r;
  logic [AW-1:0]   wr_addr_r;
  logic [DW*N-1:0] wr_data_r;
  logic            cmd_ready_r, busy_r, done_r, err_r;

  // Next-state and row-counter logic
  always_comb begin
    state_s  = state_r;
    k_s      = k_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          state_s  = LOAD_W;
          k_s      = '0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_W: begin
        if (k_r == K_LAST) begin
          state_s = WAIT_SPACE;
          k_s     = '0;
        end else begin
          k_s = k_r + CW'(1);
        end
      end
      WAIT_SPACE: begin
        if (fifo_has_space) begin
          state_s = STREAM_X;
          k_s     = '0;
        end else begin
          state_s = WAIT_SPACE;
        end
      end
      STREAM_X: begin
        if (k_r == K_LAST) begin
          state_s = DRAIN;
          k_s     = '0;
        end else begin
          k_s = k_r + CW'(1);
        end
      end
      DRAIN: begin
        if ((out_cnt_r == CNT_FULL) && drained) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        k_s     = '0;
      end
    endcase
  end

  // Read addresses for the cycle being entered; bases bypass the latch on accept
  always_comb begin
    w_base_s   = accept_s ? cmd_w_base  : w_base_r;
    x_base_s   = accept_s ? cmd_x_base  : x_base_r;
    ps_base_s  = accept_s ? cmd_ps_base : ps_base_r;
    rda_addr_s = '0;
    rdp_addr_s = '0;
    if (state_s == LOAD_W) begin
      rda_addr_s = w_base_s + AW'(k_s);
    end else if (state_s == STREAM_X) begin
      rda_addr_s = x_base_s + AW'(k_s);
      rdp_addr_s = ps_base_s + AW'(k_s);
    end else begin
      rda_addr_s = '0;
      rdp_addr_s = '0;
    end
  end

  // Writeback qualification; results outside the streaming window or beyond N are errors
  always_comb begin
    wb_ok_s = 1'b0;
    if (out_en && ((state_r == STREAM_X) || (state_r == DRAIN)) && (out_cnt_r != CNT_FULL)) begin
      wb_ok_s = 1'b1;
    end else begin
      wb_ok_s = 1'b0;
    end
    stray_s = out_en && !wb_ok_s;
  end

  // State, row counter and latched tile bases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      k_r        <= '0;
      w_base_r   <= '0;
      x_base_r   <= '0;
      ps_base_r  <= '0;
      out_base_r <= '0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      if (accept_s) begin
        w_base_r   <= cmd_w_base;
        x_base_r   <= cmd_x_base;
        ps_base_r  <= cmd_ps_base;
        out_base_r <= cmd_out_base;
      end
    end
  end

  // Read issue: strobes and addresses registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rda_en_r   <= 1'b0;
      rdp_en_r   <= 1'b0;
      rda_addr_r <= '0;
      rdp_addr_r <= '0;
    end else begin
      rda_en_r   <= (state_s == LOAD_W) || (state_s == STREAM_X);
      rdp_en_r   <= (state_s == STREAM_X);
      rda_addr_r <= rda_addr_s;
      rdp_addr_r <= rdp_addr_s;
    end
  end

  // Read-return stage: row strobe and index follow each issue by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_w_r   <= 1'b0;
      ld_x_r   <= 1'b0;
      ld_idx_r <= '0;
    end else begin
      ld_w_r   <= rda_en_r && (state_r == LOAD_W);
      ld_x_r   <= rda_en_r && (state_r == STREAM_X);
      ld_idx_r <= rda_en_r ? k_r : '0;
    end
  end

  // Result writeback, output-row count and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      out_cnt_r <= '0;
      err_r     <= 1'b0;
    end else begin
      wr_en_r   <= wb_ok_s;
      wr_addr_r <= wb_ok_s ? (out_base_r + AW'(row_out)) : '0;
      wr_data_r <= wb_ok_s ? array_output : '0;
      if (accept_s) begin
        out_cnt_r <= '0;
      end else if (wb_ok_s) begin
        out_cnt_r <= out_cnt_r + (CW+1)'(1);
      end
      err_r <= err_r | stray_s;
    end
  end

  // Handshake and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cmd_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_s == DONE);
    end
  end

  // Operand data passes straight from the scratchpad return into the array
  assign array_in          = (ld_w_r || ld_x_r) ? rda_data : '0;
  assign array_in_partials = ld_x_r ? rdp_data : '0;
  assign weight_en         = ld_w_r;
  assign input_en          = ld_x_r;
  assign partial_en        = ld_x_r;
  assign row_in_en         = ld_idx_r;
  assign row_ps_en         = ld_idx_r;
  assign rda_en            = rda_en_r;
  assign rda_addr          = rda_addr_r;
  assign rdp_en            = rdp_en_r;
  assign rdp_addr          = rdp_addr_r;
  assign wr_en             = wr_en_r;
  assign wr_addr           = wr_addr_r;
  assign wr_data           = wr_data_r;
  assign cmd_ready         = cmd_ready_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign err               = err_r;

endmodule

// File: tb/tb_sys_arr_gemm_sequencer.sv
// Directed bench for sys_arr_gemm_sequencer: a scratchpad responder plus
// queue-based scoreboard checked by a negedge monitor.
module tb_sys_arr_gemm_sequencer;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_w_base = '0, cmd_x_base = '0, cmd_ps_base = '0, cmd_out_base = '0;
  logic            rda_en, rdp_en;
  logic [AW-1:0]   rda_addr, rdp_addr;
  logic [DW*N-1:0] rda_data = '0, rdp_data = '0;
  logic            weight_en, input_en, partial_en;
  logic [CW-1:0]   row_in_en, row_ps_en;
  logic [DW*N-1:0] array_in, array_in_partials;
  logic            fifo_has_space = 1'b1, drained = 1'b0, out_en = 1'b0;
  logic [CW-1:0]   row_out = '0;
  logic [DW*N-1:0] array_output = '0;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW*N-1:0] wr_data;
  logic            busy, done, err;

  sys_arr_gemm_sequencer #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w_base(cmd_w_base), .cmd_x_base(cmd_x_base), .cmd_ps_base(cmd_ps_base),
    .cmd_out_base(cmd_out_base), .rda_en(rda_en), .rda_addr(rda_addr), .rda_data(rda_data),
    .rdp_en(rdp_en), .rdp_addr(rdp_addr), .rdp_data(rdp_data), .weight_en(weight_en),
    .input_en(input_en), .partial_en(partial_en), .row_in_en(row_in_en), .row_ps_en(row_ps_en),
    .array_in(array_in), .array_in_partials(array_in_partials), .fifo_has_space(fifo_has_space),
    .drained(drained), .out_en(out_en), .row_out(row_out), .array_output(array_output),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
  typedef struct { int cyc; logic [CW-1:0] row; logic [DW*N-1:0] d; logic [DW*N-1:0] p; } ld_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW*N-1:0] d; } wr_t;
  rd_t q_rda[$], q_rdp[$];
  ld_t q_w[$], q_x[$];
  wr_t q_wr[$];
  int  q_done[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*N-1:0] pat(input logic [AW-1:0] a, input logic [1:0] sel);
    logic [DW*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = {sel, 4'(i), a};
    return v;
  endfunction

  // Scratchpad model: data returned exactly one cycle after each read strobe
  initial begin : responder
    logic          en_a, en_p;
    logic [AW-1:0] a, p;
    forever begin
      @(negedge clk);
      en_a = rda_en; a = rda_addr; en_p = rdp_en; p = rdp_addr;
      @(posedge clk);
      #1;
      rda_data = en_a ? pat(a, 2'd0) : {N{16'hBAD0}};
      rdp_data = en_p ? pat(p, 2'd1) : {N{16'hBAD1}};
    end
  end

  rd_t mr;
  ld_t ml;
  wr_t mw;
  int  md;

  // Monitor: every DUT strobe must match the head of its expectation queue
  always @(negedge clk) begin
    if (rda_en) begin
      if (q_rda.size() == 0) chk("rda_unexpected", 64'(rda_en), 64'd0);
      else begin mr = q_rda.pop_front(); chk("rda_cyc", 64'(cyc), 64'(mr.cyc)); chk("rda_addr", 64'(rda_addr), 64'(mr.addr)); end
    end
    if (rdp_en) begin
      if (q_rdp.size() == 0) chk("rdp_unexpected", 64'(rdp_en), 64'd0);
      else begin mr = q_rdp.pop_front(); chk("rdp_cyc", 64'(cyc), 64'(mr.cyc)); chk("rdp_addr", 64'(rdp_addr), 64'(mr.addr)); end
    end
    if (weight_en || input_en) chk("w_x_overlap", 64'(weight_en && input_en), 64'd0);
    if (input_en || partial_en) chk("partial_eq_input", 64'(partial_en), 64'(input_en));
    if (weight_en) begin
      if (q_w.size() == 0) chk("weight_unexpected", 64'(weight_en), 64'd0);
      else begin
        ml = q_w.pop_front();
        chk("weight_cyc", 64'(cyc), 64'(ml.cyc));
        chk("weight_row", 64'(row_in_en), 64'(ml.row));
        chk("weight_data", array_in, ml.d);
      end
    end
    if (input_en) begin
      if (q_x.size() == 0) chk("input_unexpected", 64'(input_en), 64'd0);
      else begin
        ml = q_x.pop_front();
        chk("input_cyc", 64'(cyc), 64'(ml.cyc));
        chk("input_row", 64'(row_in_en), 64'(ml.row));
        chk("ps_row", 64'(row_ps_en), 64'(ml.row));
        chk("input_data", array_in, ml.d);
        chk("ps_data", array_in_partials, ml.p);
      end
    end
    if (wr_en) begin
      if (q_wr.size() == 0) chk("wr_unexpected", 64'(wr_en), 64'd0);
      else begin
        mw = q_wr.pop_front();
        chk("wr_cyc", 64'(cyc), 64'(mw.cyc));
        chk("wr_addr", 64'(wr_addr), 64'(mw.addr));
        chk("wr_data", wr_data, mw.d);
      end
    end
    if (done) begin
      if (q_done.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
      else begin md = q_done.pop_front(); chk("done_cyc", 64'(cyc), 64'(md)); end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue a tile; space_low = cycles fifo_has_space stays 0 in WAIT_SPACE
  task automatic start_tile(input logic [AW-1:0] w, x, ps, o, input int space_low, output int sst);
    int t0;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    t0 = cyc;
    cmd_valid = 1'b1;
    cmd_w_base = w; cmd_x_base = x; cmd_ps_base = ps; cmd_out_base = o;
    fifo_has_space = (space_low == 0);
    sst = t0 + N + 2 + space_low;
    for (int k = 0; k < N; k++) begin
      q_rda.push_back('{t0 + 1 + k, w + AW'(k)});
      q_w.push_back('{t0 + 2 + k, CW'(k), pat(w + AW'(k), 2'd0), '0});
    end
    for (int k = 0; k < N; k++) begin
      q_rda.push_back('{sst + k, x + AW'(k)});
      q_rdp.push_back('{sst + k, ps + AW'(k)});
      q_x.push_back('{sst + 1 + k, CW'(k), pat(x + AW'(k), 2'd0), pat(ps + AW'(k), 2'd1)});
    end
    step(1);
    cmd_valid = 1'b0;
    cmd_w_base = 10'h155; cmd_x_base = 10'h155; cmd_ps_base = 10'h155; cmd_out_base = 10'h155;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    if (space_low > 0) begin
      step(t0 + N + 1 + space_low - cyc);
      fifo_has_space = 1'b1;
    end
    step(sst + 1 - cyc);
    fifo_has_space = 1'b0;
  endtask

  // Emit N result rows from ost (plus optional 5th), drained from drn onward
  task automatic drive_outputs(input logic [AW-1:0] o, input int sst, input int ost,
                               input int rows[N], input bit extra, input int drn);
    int dcyc, i;
    dcyc = ost + N;
    if (drn > dcyc) dcyc = drn;
    if (sst + N > dcyc) dcyc = sst + N;
    dcyc = dcyc + 1;
    q_done.push_back(dcyc);
    step(ost - cyc);
    for (int c = ost; c <= dcyc; c++) begin
      i = c - ost;
      if (i < N) begin
        out_en = 1'b1;
        row_out = CW'(rows[i]);
        array_output = {$urandom, $urandom};
        q_wr.push_back('{c + 1, o + AW'(rows[i]), array_output});
      end else if (i == N && extra) begin
        out_en = 1'b1;
        row_out = '0;
        array_output = {$urandom, $urandom};
      end else begin
        out_en = 1'b0;
      end
      drained = (c >= drn);
      step(1);
    end
    out_en = 1'b0;
    drained = 1'b0;
    fifo_has_space = 1'b1;
    chk("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("q_w_empty", 64'(q_w.size()), 64'd0);
    chk("q_x_empty", 64'(q_x.size()), 64'd0);
    chk("q_rd_empty", 64'(q_rda.size() + q_rdp.size()), 64'd0);
    chk("q_wr_empty", 64'(q_wr.size()), 64'd0);
    chk("q_done_empty", 64'(q_done.size()), 64'd0);
  endtask

  initial begin : main
    int sst;
    #2 rst = 1'b1;
    step(2);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_strobes", 64'({rda_en, rdp_en, weight_en, input_en, wr_en}), 64'd0);
    rst = 1'b0;
    step(2);

    // Nominal tile: relative to accept, weights 2-5, inputs 7-10, writes 21-24, done 25
    start_tile(10'h010, 10'h020, 10'h030, 10'h040, 0, sst);
    drive_outputs(10'h040, sst, sst + 14, '{0, 1, 2, 3}, 1'b0, sst + 18);
    step(2);

    // FIFO stall of 10 cycles in WAIT_SPACE
    start_tile(10'h100, 10'h110, 10'h120, 10'h130, 10, sst);
    drive_outputs(10'h130, sst, sst + N + 1, '{0, 1, 2, 3}, 1'b0, sst + 2 * N + 1);
    step(1);

    // Address wrap on input reads and writeback
    start_tile(10'h200, 10'h3FE, 10'h3FC, 10'h3FE, 0, sst);
    drive_outputs(10'h3FE, sst, sst + N + 1, '{0, 1, 2, 3}, 1'b0, sst + 2 * N + 2);
    step(1);

    // Out-of-order rows with drained raised before the last row
    start_tile(10'h010, 10'h020, 10'h030, 10'h040, 0, sst);
    drive_outputs(10'h040, sst, sst + N + 2, '{3, 1, 0, 2}, 1'b0, sst + N + 2);
    chk("err_clean", 64'(err), 64'd0);
    step(1);

    // Stray out_en in IDLE: no write, sticky error
    out_en = 1'b1; row_out = 2'd1; array_output = 64'h1234;
    step(1);
    out_en = 1'b0;
    chk("err_stray_idle", 64'(err), 64'd1);
    step(2);
    start_tile(10'h050, 10'h060, 10'h070, 10'h080, 0, sst);
    drive_outputs(10'h080, sst, sst + N + 2, '{2, 3, 0, 1}, 1'b1, sst + 2 * N + 4);
    chk("err_sticky", 64'(err), 64'd1);
    step(1);

    // Reset while row 2 of the input stream is on the array
    start_tile(10'h010, 10'h020, 10'h030, 10'h040, 0, sst);
    step(sst + 3 - cyc);
    rst = 1'b1;
    #1;
    chk("midrst_strobes", 64'({rda_en, rdp_en, weight_en, input_en, partial_en, wr_en, done}), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    q_rda.delete(); q_rdp.delete(); q_w.delete(); q_x.delete(); q_wr.delete(); q_done.delete();
    fifo_has_space = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);

    // Fresh tile after reset
    start_tile(10'h0A0, 10'h0B0, 10'h0C0, 10'h0D0, 0, sst);
    drive_outputs(10'h0D0, sst, sst + N + 1, '{1, 0, 3, 2}, 1'b0, sst + 2 * N + 1);
    chk("err_after_fresh", 64'(err), 64'd0);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
